// File: rtl/vppm_period_estimator.sv
// vppm_period_estimator
//
// Upstream stage of the VPPM demodulator. During the preamble it measures the
// symbol period of VppmIn in clk cycles. It averages NUM_PERIODS consecutive
// periods that agree with a reference period within a tolerance, then freezes
// the result and raises a lock flag. The output is the average period minus 2,
// because the demodulator's sample counter runs 0..signalFrequency+1.
//
// Optional feature (macro LOSS_OF_LOCK_EN):
//   defined   - in LOCKED, a gap of 4x the locked period with no rising edge
//               drops the lock and returns to IDLE.
//   undefined - LOCKED is held until rst_n.
//
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   VppmIn          in   raw VPPM line, asynchronous to clk
//   signalFrequency out  [31:0] averaged period - 2, frozen while locked
//   freqAvailable   out  lock flag, high while signalFrequency is valid
//   periodCount     out  [24:0] live clocks since last accepted rise (debug)
module vppm_period_estimator #(
  parameter int NUM_PERIODS = 4,
  parameter int TOL_SHIFT   = 3,
  parameter int MIN_PERIOD  = 8,
  parameter int MAX_PERIOD  = 24'hFFFFFF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VppmIn,
  output logic [31:0] signalFrequency,
  output logic        freqAvailable,
  output logic [24:0] periodCount
);

  localparam int CNT_W  = 25;
  localparam int AVG_SH = $clog2(NUM_PERIODS);
  localparam int ACC_W  = CNT_W + AVG_SH;
  localparam int N_W    = AVG_SH + 1;

  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_PERIOD);
  localparam logic [N_W-1:0]   C_NUMP = N_W'(NUM_PERIODS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  // Larger minus smaller, so the difference never goes negative.
  function automatic logic [CNT_W-1:0] f_abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Mean of the accumulated periods; NUM_PERIODS is a power of two.
  function automatic logic [CNT_W-1:0] f_average(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] v_sh;
    v_sh = acc >> AVG_SH;
    return v_sh[CNT_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_ref;
  logic [ACC_W-1:0]       r_acc;
  logic [N_W-1:0]         r_n;
  state_t                 r_state;

  logic                   w_rise;
  logic                   w_sat;
  logic                   w_in_range;
  logic                   w_tol_ok;
  logic [CNT_W-1:0]       w_avg;

  // Synchroniser chain followed by the edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], VppmIn};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // Period counter: restarts at 1 on every rise, parks at MAX_PERIOD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt < C_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // r_cnt still holds the just-finished period P in the rise cycle.
  assign w_sat      = (r_cnt == C_MAX);
  assign w_in_range = (r_cnt >= C_MIN) && (r_cnt <= (C_MAX - CNT_W'(1)));
  assign w_tol_ok   = (f_abs_diff(r_cnt, r_ref) <= (r_ref >> TOL_SHIFT));
  assign w_avg      = f_average(r_acc);

`ifdef LOSS_OF_LOCK_EN
  logic [CNT_W-1:0] r_lock_per;
  logic [CNT_W+1:0] w_lol_x4;
  logic [CNT_W-1:0] w_lol_limit;
  logic             w_lol;

  assign w_lol_x4    = {r_lock_per, 2'b00};
  assign w_lol_limit = (w_lol_x4 >= {2'b00, C_MAX}) ? C_MAX : w_lol_x4[CNT_W-1:0];
  assign w_lol       = (r_cnt >= w_lol_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_per <= '0;
    end else if (r_state == S_MEASURE && r_n == C_NUMP) begin
      r_lock_per <= w_avg;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ref           <= '0;
      r_acc           <= '0;
      r_n             <= '0;
      signalFrequency <= '0;
      freqAvailable   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_acc   <= '0;
            r_n     <= '0;
          end
        end
        S_MEASURE: begin
          if (r_n == C_NUMP) begin
            r_state         <= S_LOCKED;
            signalFrequency <= 32'(w_avg) - 32'd2;
            freqAvailable   <= 1'b1;
          end else if (w_rise) begin
            if (r_n == '0) begin
              // First period after a (re)start becomes the reference.
              if (w_in_range) begin
                r_ref <= r_cnt;
                r_acc <= ACC_W'(r_cnt);
                r_n   <= N_W'(1);
              end
            end else if (w_in_range && w_tol_ok) begin
              r_acc <= r_acc + ACC_W'(r_cnt);
              r_n   <= r_n + N_W'(1);
            end else begin
              // Outlier: this edge is the new start, reference re-taken.
              r_acc <= '0;
              r_n   <= '0;
            end
          end else if (w_sat) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_n     <= '0;
          end
        end
        S_LOCKED: begin
          // Data edges sit at 0 or T/2 offsets, so no tolerance check here.
`ifdef LOSS_OF_LOCK_EN
          if (!w_rise && w_lol) begin
            r_state         <= S_IDLE;
            signalFrequency <= '0;
            freqAvailable   <= 1'b0;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign periodCount = r_cnt;

endmodule
